// File: rtl/fifo_cmd_arbiter.sv
// Command arbiter in front of an 8-entry buffer: merges producer writes and consumer
// read requests into one buffer command per cycle and returns read data after two cycles.
module fifo_cmd_arbiter #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             buf_valid,
  output logic             buf_wr_rd,
  output logic [WIDTH-1:0] buf_wdata,
  input  logic [WIDTH-1:0] buf_rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

  grant_e     last_grant;
  logic       wr_legal;
  logic       rd_legal;
  logic       wr_grant;
  logic       rd_grant;
  logic [1:0] rd_pipe;

  assign wr_legal = (count < CW'(DEPTH));
  assign rd_legal = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wr_ready = wr_grant;
  assign rd_ready = rd_grant;

  // Occupancy limits override round-robin when both sides contend.
  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (wr_valid && rd_req) begin
      if (!rd_legal) begin
        wr_grant = wr_legal;
      end else if (!wr_legal) begin
        rd_grant = 1'b1;
      end else if (last_grant == GRANT_READ) begin
        wr_grant = 1'b1;
      end else begin
        rd_grant = 1'b1;
      end
    end else if (wr_valid) begin
      wr_grant = wr_legal;
    end else if (rd_req) begin
      rd_grant = rd_legal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      last_grant <= GRANT_READ;
      buf_valid  <= 1'b0;
      buf_wr_rd  <= 1'b0;
      buf_wdata  <= '0;
    end else begin
      buf_valid <= wr_grant || rd_grant;
      if (wr_grant) begin
        count      <= count + CW'(1);
        last_grant <= GRANT_WRITE;
        buf_wr_rd  <= 1'b1;
        buf_wdata  <= wr_data;
      end else if (rd_grant) begin
        count      <= count - CW'(1);
        last_grant <= GRANT_READ;
        buf_wr_rd  <= 1'b0;
      end
    end
  end

  // Buffer samples the read at E+1 and drives data by E+2, where it is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe  <= 2'b00;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pipe  <= {rd_pipe[0], rd_grant};
      rd_valid <= rd_pipe[1];
      if (rd_pipe[1]) begin
        rd_data <= buf_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fifo_cmd_arbiter.sv
// Directed bench for fifo_cmd_arbiter with a simple 8-entry buffer model behind it.
module tb_fifo_cmd_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_req;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        buf_valid;
  logic        buf_wr_rd;
  logic [31:0] buf_wdata;
  logic [31:0] buf_rdata;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  logic [31:0] mem [8];
  logic [2:0]  wp;
  logic [2:0]  rp;

  int checks = 0;
  int errors = 0;

  logic        exp_rv [6];
  logic [31:0] exp_rd [6];

  fifo_cmd_arbiter #(.DEPTH(8), .WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_req   (rd_req),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .buf_valid(buf_valid),
    .buf_wr_rd(buf_wr_rd),
    .buf_wdata(buf_wdata),
    .buf_rdata(buf_rdata),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: stores on write commands, presents the oldest word after a read command.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      buf_rdata <= '0;
    end else if (buf_valid) begin
      if (buf_wr_rd) begin
        wp <= wp + 3'd1;
      end else begin
        buf_rdata <= mem[rp];
        rp        <= rp + 3'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && buf_valid && buf_wr_rd) begin
      mem[wp] <= buf_wdata;
    end
  end

  task automatic applyStimulus(input logic wv, input logic [31:0] wd, input logic rr);
    wr_valid = wv;
    wr_data  = wd;
    rd_req   = rr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    exp_rv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_rd = '{32'h33, 32'h44, 32'h0, 32'h55, 32'h0, 32'h66};
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_req   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_buf_valid", 32'(buf_valid), 32'd0);
    checkOutput("rst_buf_wr_rd", 32'(buf_wr_rd), 32'd0);
    checkOutput("rst_buf_wdata", buf_wdata, 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] fill to full");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'((i + 1) * 32'h11), 1'b0);
      checkOutput("fill_wr_ready", 32'(wr_ready), 32'd1);
      tick();
      checkOutput("fill_count", 32'(count), 32'(i + 1));
      checkOutput("fill_buf_valid", 32'(buf_valid), 32'd1);
      checkOutput("fill_buf_wr_rd", 32'(buf_wr_rd), 32'd1);
      checkOutput("fill_buf_wdata", buf_wdata, 32'((i + 1) * 32'h11));
    end
    checkOutput("full_flag", 32'(full), 32'd1);
    checkOutput("full_empty", 32'(empty), 32'd0);
    applyStimulus(1'b1, 32'h99, 1'b0);
    checkOutput("ninth_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    checkOutput("ninth_buf_valid", 32'(buf_valid), 32'd0);
    checkOutput("ninth_count", 32'(count), 32'd8);
    checkOutput("ninth_wdata_held", buf_wdata, 32'h88);

    $display("[TB] contention at full, then reads down to 4");
    applyStimulus(1'b1, 32'h99, 1'b1);
    checkOutput("full_cont_rd_ready", 32'(rd_ready), 32'd1);
    checkOutput("full_cont_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    checkOutput("full_cont_count", 32'(count), 32'd7);
    checkOutput("full_cont_buf_valid", 32'(buf_valid), 32'd1);
    checkOutput("full_cont_buf_wr_rd", 32'(buf_wr_rd), 32'd0);
    checkOutput("full_cont_wdata_held", buf_wdata, 32'h88);
    checkOutput("full_cont_rd_valid", 32'(rd_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("rd2_count", 32'(count), 32'd6);
    checkOutput("rd2_rd_valid", 32'(rd_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("rd3_count", 32'(count), 32'd5);
    checkOutput("rd3_rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("rd3_rd_data", rd_data, 32'h11);
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("rd4_count", 32'(count), 32'd4);
    checkOutput("rd4_rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("rd4_rd_data", rd_data, 32'h22);

    $display("[TB] round-robin from count 4");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 32'(32'hA0 + (k + 1) / 2), 1'b1);
      checkOutput("rr_wr_ready", 32'(wr_ready), 32'((k % 2) == 0));
      checkOutput("rr_rd_ready", 32'(rd_ready), 32'((k % 2) == 1));
      tick();
      checkOutput("rr_count", 32'(count), ((k % 2) == 0) ? 32'd5 : 32'd4);
      checkOutput("rr_rd_valid", 32'(rd_valid), 32'(exp_rv[k]));
      if (exp_rv[k]) begin
        checkOutput("rr_rd_data", rd_data, exp_rd[k]);
      end
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("rr_tail_gap", 32'(rd_valid), 32'd0);
    tick();
    checkOutput("rr_tail_rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("rr_tail_rd_data", rd_data, 32'h77);
    tick();
    checkOutput("rr_tail_pulse_end", 32'(rd_valid), 32'd0);
    checkOutput("rr_end_count", 32'(count), 32'd4);

    $display("[TB] drain and read from empty");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      tick();
    end
    checkOutput("drain_count", 32'(count), 32'd0);
    checkOutput("drain_empty", 32'(empty), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("empty_rd_ready", 32'(rd_ready), 32'd0);
      tick();
      checkOutput("empty_buf_valid", 32'(buf_valid), 32'd0);
      checkOutput("empty_rd_valid", 32'(rd_valid), 32'd0);
    end

    $display("[TB] contention at empty and read latency");
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
    checkOutput("empty_cont_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("empty_cont_rd_ready", 32'(rd_ready), 32'd0);
    tick();
    checkOutput("empty_cont_count", 32'(count), 32'd1);
    checkOutput("empty_cont_wdata", buf_wdata, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("lat_rd_ready", 32'(rd_ready), 32'd1);
    tick();
    checkOutput("lat_count", 32'(count), 32'd0);
    checkOutput("lat_buf_wr_rd", 32'(buf_wr_rd), 32'd0);
    checkOutput("lat_wdata_held", buf_wdata, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("lat_e1_rd_valid", 32'(rd_valid), 32'd0);
    tick();
    checkOutput("lat_e2_rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("lat_e2_rd_data", rd_data, 32'hDEADBEEF);
    tick();
    checkOutput("lat_e3_rd_valid", 32'(rd_valid), 32'd0);

    $display("[TB] reset with a read in flight");
    applyStimulus(1'b1, 32'h12345678, 1'b0);
    tick();
    checkOutput("mid_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("mid_rd_ready", 32'(rd_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_buf_valid", 32'(buf_valid), 32'd0);
    checkOutput("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("mid_rst_empty", 32'(empty), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("post_rst_rd_valid", 32'(rd_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
